// File: rtl/jpeg_ac_rle_encoder.sv
// jpeg_ac_rle_encoder: zig-zag coefficients in, JPEG run/size/amp out.
// One DC symbol per block, AC symbols with zero runs, ZRL and EOB.
module jpeg_ac_rle_encoder #(
    parameter int COEF_W  = 12,
    parameter int BLK_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_run,
    output logic [3:0]               out_size,
    output logic [COEF_W-2:0]        out_amp,
    output logic                     out_dc,
    output logic                     out_eob,
    output logic                     out_zrl,
    output logic                     blk_done,
    output logic                     err_sync
);

    localparam logic [5:0] LAST_IDX = 6'(BLK_LEN - 1);
    localparam logic [COEF_W-2:0] ONE = {{(COEF_W-2){1'b0}}, 1'b1};
    localparam logic signed [COEF_W-1:0] MOST_NEG =
        {1'b1, {(COEF_W-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] SAT_NEG =
        {1'b1, {(COEF_W-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ACCEPT,
        EMIT_ZRL,
        EMIT_EOB
    } state_t;

    state_t              r_state;
    logic [5:0]          r_idx;
    logic [5:0]          r_run;
    logic [1:0]          r_zrl_left;
    logic [3:0]          r_pend_run;
    logic [3:0]          r_pend_size;
    logic [COEF_W-2:0]   r_pend_amp;
    logic                r_pend_last;
    logic                r_err;

    logic                r_out_valid;
    logic [3:0]          r_out_run;
    logic [3:0]          r_out_size;
    logic [COEF_W-2:0]   r_out_amp;
    logic                r_out_dc;
    logic                r_out_eob;
    logic                r_out_zrl;
    logic                r_out_last;

    logic                w_can_load;
    logic                w_acc;
    logic                w_idx_last;
    logic                w_is_dc;
    logic                w_zero;
    logic                w_run_big;

    logic signed [COEF_W-1:0] w_sat;
    logic [COEF_W-2:0]   w_mag;
    logic [3:0]          w_size;
    logic [COEF_W-2:0]   w_mask;
    logic [COEF_W-2:0]   w_amp;

    logic                w_ld;
    logic [3:0]          w_ld_run;
    logic [3:0]          w_ld_size;
    logic [COEF_W-2:0]   w_ld_amp;
    logic                w_ld_dc;
    logic                w_ld_eob;
    logic                w_ld_zrl;
    logic                w_ld_last;

    assign w_can_load = !r_out_valid || out_ready;
    assign in_ready   = !rst && (r_state == ACCEPT) && w_can_load;
    assign w_acc      = in_valid && in_ready;
    assign w_idx_last = (r_idx == LAST_IDX);
    assign w_is_dc    = (r_idx == 6'd0);
    assign w_zero     = (in_coef == '0);
    assign w_run_big  = (r_run[5:4] != 2'b00);

    // Magnitude category and ones'-complement amplitude of the input
    always_comb begin
        w_sat = (in_coef == MOST_NEG) ? SAT_NEG : in_coef;
        w_mag = w_sat[COEF_W-1] ? (~w_sat[COEF_W-2:0] + ONE)
                                : w_sat[COEF_W-2:0];
        w_size = 4'd0;
        for (int i = 0; i < COEF_W - 1; i++) begin
            if (w_mag[i]) w_size = 4'(i + 1);
        end
        w_mask = (ONE << w_size) - ONE;
        w_amp  = (w_sat[COEF_W-1] ? (w_sat[COEF_W-2:0] - ONE)
                                  : w_sat[COEF_W-2:0]) & w_mask;
    end

    // Pick the symbol to load into the output register this cycle
    always_comb begin
        w_ld      = 1'b0;
        w_ld_run  = 4'd0;
        w_ld_size = 4'd0;
        w_ld_amp  = '0;
        w_ld_dc   = 1'b0;
        w_ld_eob  = 1'b0;
        w_ld_zrl  = 1'b0;
        w_ld_last = 1'b0;
        case (r_state)
            ACCEPT: begin
                if (w_acc && w_is_dc) begin
                    w_ld      = 1'b1;
                    w_ld_dc   = 1'b1;
                    w_ld_size = w_size;
                    w_ld_amp  = w_amp;
                end else if (w_acc && !w_zero && w_run_big) begin
                    w_ld      = 1'b1;
                    w_ld_zrl  = 1'b1;
                    w_ld_run  = 4'd15;
                end else if (w_acc && !w_zero) begin
                    w_ld      = 1'b1;
                    w_ld_run  = r_run[3:0];
                    w_ld_size = w_size;
                    w_ld_amp  = w_amp;
                    w_ld_last = w_idx_last;
                end
            end
            EMIT_ZRL: begin
                if (w_can_load) begin
                    w_ld = 1'b1;
                    if (r_zrl_left != 2'd0) begin
                        w_ld_zrl = 1'b1;
                        w_ld_run = 4'd15;
                    end else begin
                        w_ld_run  = r_pend_run;
                        w_ld_size = r_pend_size;
                        w_ld_amp  = r_pend_amp;
                        w_ld_last = r_pend_last;
                    end
                end
            end
            EMIT_EOB: begin
                if (w_can_load) begin
                    w_ld      = 1'b1;
                    w_ld_eob  = 1'b1;
                    w_ld_last = 1'b1;
                end
            end
            default: begin
                w_ld = 1'b0;
            end
        endcase
    end

    // Output register: load a new symbol, or empty it once drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_run   <= 4'd0;
            r_out_size  <= 4'd0;
            r_out_amp   <= '0;
            r_out_dc    <= 1'b0;
            r_out_eob   <= 1'b0;
            r_out_zrl   <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_ld) begin
            r_out_valid <= 1'b1;
            r_out_run   <= w_ld_run;
            r_out_size  <= w_ld_size;
            r_out_amp   <= w_ld_amp;
            r_out_dc    <= w_ld_dc;
            r_out_eob   <= w_ld_eob;
            r_out_zrl   <= w_ld_zrl;
            r_out_last  <= w_ld_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Block framing, zero-run counting and ZRL/EOB sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCEPT;
            r_idx       <= 6'd0;
            r_run       <= 6'd0;
            r_zrl_left  <= 2'd0;
            r_pend_run  <= 4'd0;
            r_pend_size <= 4'd0;
            r_pend_amp  <= '0;
            r_pend_last <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ACCEPT: begin
                    if (w_acc) begin
                        r_idx <= w_idx_last ? 6'd0 : r_idx + 6'd1;
                        if (in_last != w_idx_last) r_err <= 1'b1;
                        if (w_is_dc) begin
                            r_run <= 6'd0;
                        end else if (w_zero) begin
                            r_run <= w_idx_last ? 6'd0 : r_run + 6'd1;
                            if (w_idx_last) r_state <= EMIT_EOB;
                        end else begin
                            r_run <= 6'd0;
                            if (w_run_big) begin
                                r_state     <= EMIT_ZRL;
                                r_zrl_left  <= r_run[5:4] - 2'd1;
                                r_pend_run  <= r_run[3:0];
                                r_pend_size <= w_size;
                                r_pend_amp  <= w_amp;
                                r_pend_last <= w_idx_last;
                            end
                        end
                    end
                end
                EMIT_ZRL: begin
                    if (w_can_load) begin
                        if (r_zrl_left != 2'd0) begin
                            r_zrl_left <= r_zrl_left - 2'd1;
                        end else begin
                            r_state <= ACCEPT;
                        end
                    end
                end
                EMIT_EOB: begin
                    if (w_can_load) r_state <= ACCEPT;
                end
                default: begin
                    r_state <= ACCEPT;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_run   = r_out_run;
    assign out_size  = r_out_size;
    assign out_amp   = r_out_amp;
    assign out_dc    = r_out_dc;
    assign out_eob   = r_out_eob;
    assign out_zrl   = r_out_zrl;
    assign blk_done  = r_out_valid && out_ready && r_out_last;
    assign err_sync  = r_err;

endmodule

// File: tb/tb_jpeg_ac_rle_encoder.sv
// tb_jpeg_ac_rle_encoder: directed and random blocks against a
// behavioural JPEG run-length model, with output stall checks.
module tb_jpeg_ac_rle_encoder;

    localparam int COEF_W = 12;
    localparam int BUDGET = 3000;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_coef;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_run;
    logic [3:0]               out_size;
    logic [COEF_W-2:0]        out_amp;
    logic                     out_dc;
    logic                     out_eob;
    logic                     out_zrl;
    logic                     blk_done;
    logic                     err_sync;

    int total = 0;
    int bad = 0;
    int blk [64];
    int acc_first;
    int acc_last;
    logic [21:0] exp_q [$];
    logic [21:0] got_q [$];

    jpeg_ac_rle_encoder #(
        .COEF_W (COEF_W),
        .BLK_LEN(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_coef  (in_coef),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_run  (out_run),
        .out_size (out_size),
        .out_amp  (out_amp),
        .out_dc   (out_dc),
        .out_eob  (out_eob),
        .out_zrl  (out_zrl),
        .blk_done (blk_done),
        .err_sync (err_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < -2047) ? -2047 : v;
    endfunction

    function automatic int sz(input int v);
        int m;
        int s;
        m = (v < 0) ? -v : v;
        s = 0;
        while (m > 0) begin
            s++;
            m = m >> 1;
        end
        return s;
    endfunction

    function automatic int ampl(input int v);
        if (v > 0) return v;
        if (v < 0) return v + (1 << sz(v)) - 1;
        return 0;
    endfunction

    function automatic logic [21:0] mk(input bit dc, input bit eob,
                                       input bit zrl, input int run,
                                       input int s, input int a);
        return {dc, eob, zrl, 4'(run), 4'(s), 11'(a)};
    endfunction

    task automatic build_expected();
        int run;
        int v;
        exp_q = {};
        v = sat(blk[0]);
        exp_q.push_back(mk(1, 0, 0, 0, sz(v), ampl(v)));
        run = 0;
        for (int k = 1; k < 64; k++) begin
            v = sat(blk[k]);
            if (v == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(mk(0, 0, 1, 15, 0, 0));
                    run -= 16;
                end
                exp_q.push_back(mk(0, 0, 0, run, sz(v), ampl(v)));
                run = 0;
            end
        end
        if (blk[63] == 0) exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    endtask

    function automatic int rnd_coef(input int density);
        int m;
        int r;
        r = int'($urandom_range(0, 99));
        if (r >= density) return 0;
        r = int'($urandom_range(0, 99));
        if (r < 70) begin
            m = int'($urandom_range(1, 15));
            return ($urandom_range(0, 1) == 1) ? -m : m;
        end
        if (r < 95) return int'($urandom_range(0, 4095)) - 2048;
        return -2048;
    endfunction

    task automatic clear_blk();
        for (int k = 0; k < 64; k++) blk[k] = 0;
    endtask

    task automatic run_block(input string tag, input int stall_pct,
                             input int last_at, input bit exp_err);
        int k;
        int cyc;
        int nsym;
        bit held;
        logic [21:0] held_sym;
        logic [21:0] cur;
        k = 0;
        cyc = 0;
        held = 1'b0;
        held_sym = '0;
        build_expected();
        got_q = {};
        nsym = exp_q.size();
        while ((k < 64 || got_q.size() < nsym) && cyc < BUDGET) begin
            @(negedge clk);
            in_valid  = (k < 64);
            in_coef   = (k < 64) ? COEF_W'(blk[k]) : '0;
            in_last   = (k == last_at);
            out_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            #1;
            cur = {out_dc, out_eob, out_zrl, out_run, out_size, out_amp};
            if (held) begin
                check({tag, " hold"}, {out_valid, cur}, {1'b1, held_sym});
            end
            held = out_valid && !out_ready;
            held_sym = cur;
            if (out_valid && out_zrl) begin
                check({tag, " zrl_ready"}, 32'(in_ready), 32'd0);
            end
            check({tag, " blk_done"}, 32'(blk_done),
                  32'(out_valid && out_ready && got_q.size() == nsym - 1));
            if (out_valid && out_ready) got_q.push_back(cur);
            if (in_valid && in_ready) begin
                if (k == 0) acc_first = cyc;
                if (k == 63) acc_last = cyc;
                k++;
            end
            cyc++;
        end
        check({tag, " budget"}, 32'(cyc < BUDGET), 32'd1);
        check({tag, " count"}, 32'(got_q.size()), 32'(nsym));
        for (int i = 0; i < nsym && i < got_q.size(); i++) begin
            check($sformatf("%s sym%0d", tag, i), 32'(got_q[i]),
                  32'(exp_q[i]));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check({tag, " err_sync"}, 32'(err_sync), 32'(exp_err));
    endtask

    task automatic push(input int v);
        int w;
        w = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_coef   = COEF_W'(v);
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("push wait", 32'(w < 100), 32'd1);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_coef   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst outputs",
              32'({out_valid, out_dc, out_eob, out_zrl, out_run, out_size,
                   out_amp, blk_done, err_sync, in_ready}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_coef   = '0;
        out_ready = 1'b0;
        acc_first = 0;
        acc_last  = 0;
        do_reset();

        clear_blk();
        run_block("allzero", 0, 63, 1'b0);
        check("allzero span", 32'(acc_last - acc_first + 1), 32'd64);

        clear_blk();
        blk[0] = 5;
        blk[1] = -3;
        run_block("dc_ac", 0, 63, 1'b0);

        clear_blk();
        blk[21] = 7;
        run_block("zrl1", 0, 63, 1'b0);

        clear_blk();
        for (int k = 1; k < 16; k++) blk[k] = 1;
        blk[63] = -1;
        run_block("zrl2", 0, 63, 1'b0);
        run_block("zrl2 stall", 50, 63, 1'b0);

        clear_blk();
        blk[0]  = -2048;
        blk[1]  = 2047;
        blk[2]  = -2048;
        blk[5]  = -1;
        blk[40] = 1024;
        run_block("extremes", 30, 63, 1'b0);

        for (int b = 0; b < 20; b++) begin
            int dens;
            dens = (b % 4 == 0) ? 5 : int'($urandom_range(10, 80));
            for (int k = 0; k < 64; k++) blk[k] = rnd_coef(dens);
            run_block($sformatf("rand%0d", b),
                      int'($urandom_range(0, 70)), 63, 1'b0);
        end

        clear_blk();
        blk[29] = 9;
        for (int k = 0; k < 30; k++) push(blk[k]);
        #1;
        check("midrst pending", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("midrst drop", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 64; k++) blk[k] = rnd_coef(30);
        run_block("after rst", 20, 63, 1'b0);

        clear_blk();
        blk[0] = 3;
        blk[12] = -6;
        run_block("err", 10, 10, 1'b1);
        for (int k = 0; k < 64; k++) blk[k] = rnd_coef(40);
        run_block("err held", 10, 63, 1'b1);
        do_reset();
        check("err cleared", 32'(err_sync), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_ac_rle_encoder.md
Name: jpeg_ac_rle_encoder

Overview:
- Entropy-front-end stage that consumes zig-zag-ordered quantized coefficients, 64 per 8x8 block, and produces JPEG run/size/amplitude symbols for the Huffman coder downstream.
- Emits one DC symbol per block, AC symbols with zero-run counts, ZRL (15,0) for runs of 16 or more zeros, and EOB (0,0) for trailing zeros.
- Sits between the quantizer/zig-zag buffer and the Huffman table lookup.
- Valid/ready handshake on both sides.

Parameters:
- COEF_W, 12, signed coefficient width (two's complement).
- BLK_LEN, 64, coefficients per block. Fixed at 64 for baseline JPEG; other values are unsupported.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  coefficient valid.
- in_ready  output  1  stage accepts coefficient this cycle.
- in_coef  input  COEF_W  signed coefficient, zig-zag order; index 0 = DC.
- in_last  input  1  asserted by upstream with coefficient index 63.
- out_valid  output  1  symbol valid.
- out_ready  input  1  downstream accepts symbol.
- out_run  output  4  zero run preceding the coefficient (0..15).
- out_size  output  4  magnitude category (0..11).
- out_amp  output  COEF_W-1  amplitude bits; low out_size bits significant, upper bits zero.
- out_dc  output  1  symbol is the block DC.
- out_eob  output  1  symbol is EOB.
- out_zrl  output  1  symbol is ZRL.
- blk_done  output  1  one-cycle pulse when the block's final symbol handshakes.
- err_sync  output  1  sticky; set on in_last/index mismatch; cleared only by rst.

Behaviour:
- Reset: synchronous, active-high. All outputs 0. Index counter 0, zero-run counter 0, FSM in ACCEPT.
- Reset mid-block: discards partial block and any pending symbol; out_valid drops on the next edge.
- FSM states: ACCEPT, EMIT_ZRL, EMIT_EOB.
- Output register: single stage. out_valid and all out_* fields hold stable until out_ready. It is loaded only when empty or draining in the same cycle.
- in_ready = (state==ACCEPT) && (!out_valid || out_ready).
- Coefficient accept: occurs when in_valid && in_ready. Symbol latency is 1 cycle (appears on the edge after accept).
- Size: number of bits of |coef|; 0 for coef=0. A coef of -2^(COEF_W-1) is saturated to -(2^(COEF_W-1)-1) before size/amp computation.
- Amp: coef if coef>0; coef-1 if coef<0, truncated to size bits (JPEG ones'-complement form).
- Index 0: emit out_dc=1, run=0, size/amp from coef. A zero DC still emits (0,0,0).
- AC, coef==0: zero-run counter increments (6 bits). No symbol is emitted and the input stays ready.
- AC, coef!=0, run<16: emit (run, size, amp) directly; run resets to 0.
- AC, coef!=0, run>=16:
  - Latch the coefficient and go to EMIT_ZRL.
  - Emit floor(run/16) ZRL symbols (run=15, size=0, out_zrl=1), one per output handshake.
  - Then emit (run mod 16, size, amp) and return to ACCEPT.
  - in_ready=0 throughout.
- Index 63, coef==0: go to EMIT_EOB. Pending ZRLs are discarded, per JPEG. Emit one EOB (run 0, size 0, out_eob=1).
- Index 63, coef!=0: final symbol(s) as above; no EOB.
- blk_done pulses on the handshake of the block's last symbol. Index and run counters return to 0 for the next block; a new block may be accepted the same cycle the output drains.
- err_sync:
  - Set if in_last accepted at index != 63, or index 63 accepted without in_last.
  - On either case the block is still closed at index 63 by counter; in_last is ignored for framing.
- Simultaneous load and drain of the output register is allowed; there are no bubbles under continuous out_ready.

Test Plan:
- All-zero block, out_ready=1 -> exactly 2 symbols: DC (run0,size0,amp0,out_dc=1), then EOB; blk_done once; 64 accepts in 64 cycles.
- coef[0]=5, coef[1]=-3, rest 0 -> DC (0,3,101b); AC (0,2,00b); EOB; 3 symbols total.
- coef[0]=0, coef[21]=7, rest 0 (20 zeros before) -> DC (0,0,0); ZRL; (4,3,111b); EOB. in_ready low during ZRL emission.
- coef[1..15]=1, coef[16..62]=0, coef[63]=-1 -> DC; 15x (0,1,1); 2x ZRL; (15,1,0); no EOB; blk_done on the last symbol.
- Random out_ready stalls (50%) on the previous case -> identical symbol sequence; fields stable while out_valid && !out_ready.
- Reset asserted at index 30 with a symbol pending -> out_valid=0 the next cycle; the following block is encoded correctly from index 0. Separately, in_last at index 10 -> err_sync=1 and held.
